mul_sequencer: RTL

Multicycle controller that sequences the combinational 32x32 signed `booth_multiplier` for the CPU's MUL instruction. It accepts operands on a start/ready handshake, holds them stable for a fixed number of clock cycles so the multiplier's combinational path can be constrained as multicycle, then captures the 64-bit product into HI/LO result registers with a one-cycle write pulse. It sits between the control unit, which issues `start`, and the HI/LO registers of the datapath.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/booth_multiplier.sv | 13 +
 rtl/mul_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: multiply sequencer state encoding and sizing constants.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int MAX_CYCLES = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/booth_multiplier.sv
// Combinational 32x32 signed multiplier; full 64-bit product, meant to be
// constrained as a multicycle path by its sequencer.
module booth_multiplier
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] p
);

  assign p = $signed(a) * $signed(b);

endmodule

// File: rtl/mul_sequencer.sv
// Multicycle sequencer for booth_multiplier: holds operands MUL_CYCLES cycles,
// then writes HI/LO. Optional zero-operand bypass via `MUL_ZERO_SKIP_EN.
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              hi_en,
  output logic              lo_en,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic [2*DATA_W-1:0] prod;

  booth_multiplier u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = mcand;
          b_d     = mplier;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          state_d = ST_WAIT;
`ifdef MUL_ZERO_SKIP_EN
          if (mcand == '0 || mplier == '0) begin
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b1;
            state_d = ST_WRITE;
          end
`else
`endif
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = ST_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_WAIT) || (state_q == ST_WRITE);
  assign done   = done_q;
  assign hi_en  = done_q;
  assign lo_en  = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
